chess_timer_display: RTL and testbench



---
 rtl/chess_timer_display.sv | 197 +++++++++++++++++++
 tb/tb_chess_timer_display.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/chess_timer_display.sv
// N-player chess clock with a 4-digit multiplexed seven-segment display.
// Each player's MM:SS lives in its own lane. The top level owns the game FSM,
// the 1 s prescaler and the digit scan.

// Per-player BCD time store: setup adjust, restore and borrow countdown.
module chess_timer_lane #(
  parameter int INIT_MIN = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            set_mode,
  input  logic            inc_min,
  input  logic            dec_min,
  input  logic            dec_sec,
  output logic [3:0][3:0] dig
);
  localparam logic [3:0] IT = 4'(INIT_MIN / 10);
  localparam logic [3:0] IO = 4'(INIT_MIN % 10);

  logic [3:0] mt, mo, st, so;

  // Digit order matches the scan slot: [3]=min_tens .. [0]=sec_ones.
  assign dig = {mt, mo, st, so};

  // Restore, setup adjust (seconds pinned to 00), or one-second borrow decrement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mt <= IT; mo <= IO; st <= 4'd0; so <= 4'd0;
    end else if (load) begin
      mt <= IT; mo <= IO; st <= 4'd0; so <= 4'd0;
    end else if (set_mode) begin
      st <= 4'd0;
      so <= 4'd0;
      if (inc_min && !(mt == 4'd9 && mo == 4'd9)) begin
        if (mo == 4'd9) begin mo <= 4'd0; mt <= mt + 4'd1; end
        else mo <= mo + 4'd1;
      end else if (dec_min && !(mt == 4'd0 && mo <= 4'd1)) begin
        if (mo == 4'd0) begin mo <= 4'd9; mt <= mt - 4'd1; end
        else mo <= mo - 4'd1;
      end
    end else if (dec_sec && {mt, mo, st, so} != 16'd0) begin
      if (so != 4'd0) so <= so - 4'd1;
      else begin
        so <= 4'd9;
        if (st != 4'd0) st <= st - 4'd1;
        else begin
          st <= 4'd5;
          if (mo != 4'd0) mo <= mo - 4'd1;
          else begin mo <= 4'd9; mt <= mt - 4'd1; end
        end
      end
    end
  end
endmodule

module chess_timer_display #(
  parameter int CLK_FREQ    = 100000000,
  parameter int REFRESH_DIV = 60000,
  parameter int NUM_PLAYERS = 2,
  parameter int INIT_MIN    = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           btn_c,
  input  logic                           btn_l,
  input  logic                           btn_u,
  input  logic                           btn_d,
  output logic [3:0]                     anode_active,
  output logic [6:0]                     segments,
  output logic                           decimal,
  output logic [$clog2(NUM_PLAYERS)-1:0] active_player,
  output logic                           timeout
);
  localparam int AW = $clog2(NUM_PLAYERS);
  localparam int PW = $clog2(CLK_FREQ);
  localparam int RW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {S_SET, S_RUN, S_PAUSE, S_TMO} state_t;

  state_t                             state, st_nxt;
  logic [AW-1:0]                      act_nxt;
  logic [PW-1:0]                      presc;
  logic [RW-1:0]                      rcnt;
  logic [1:0]                         slot;
  logic                               tick, half, act_last, load, cnt_en;
  logic [NUM_PLAYERS-1:0]             dec_sec;
  logic [NUM_PLAYERS-1:0][3:0][3:0]   pdig;
  logic [3:0][3:0]                    adig;
  logic [3:0]                         digit;

  assign tick     = (state == S_RUN) && enable && (presc == PW'(CLK_FREQ - 1));
  assign half     = presc < PW'(CLK_FREQ / 2);
  assign cnt_en   = enable && (state == S_RUN || state == S_TMO);
  assign adig     = pdig[active_player];
  // 00:00 counts as last too, so a clock paused on the final tick still times out.
  assign act_last = (adig == 16'h0001) || (adig == 16'h0000);
  assign load     = (state == S_PAUSE && !btn_c && btn_u && btn_d) ||
                    (state == S_TMO && btn_c);

  // Next game state and player; btn_c outranks btn_l and the timeout check.
  always_comb begin
    st_nxt  = state;
    act_nxt = active_player;
    case (state)
      S_SET:   if (btn_c) st_nxt = S_RUN;
      S_RUN: begin
        if (btn_c)                 st_nxt = S_PAUSE;
        else if (tick && act_last) st_nxt = S_TMO;
        else if (btn_l)
          act_nxt = (active_player == AW'(NUM_PLAYERS - 1)) ? '0 : active_player + AW'(1);
      end
      S_PAUSE: begin
        if (btn_c) st_nxt = S_RUN;
        else if (btn_u && btn_d) begin st_nxt = S_SET; act_nxt = '0; end
      end
      S_TMO:   if (btn_c) begin st_nxt = S_SET; act_nxt = '0; end
      default: st_nxt = S_SET;
    endcase
  end

  // Only the active lane sees the tick; a same-cycle btn_l still hits the old player.
  always_comb begin
    dec_sec = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      dec_sec[i] = tick && (active_player == AW'(i));
  end

  chess_timer_lane #(.INIT_MIN(INIT_MIN)) u_lane [NUM_PLAYERS-1:0] (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .set_mode(state == S_SET),
    .inc_min (btn_u & ~btn_d),
    .dec_min (btn_d & ~btn_u),
    .dec_sec (dec_sec),
    .dig     (pdig)
  );

  // Game state, player index and registered timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_SET;
      active_player <= '0;
      timeout       <= 1'b0;
    end else begin
      state         <= st_nxt;
      active_player <= act_nxt;
      timeout       <= (st_nxt == S_TMO);
    end
  end

  // 1 s prescaler; restarts whenever the state or the player changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc <= '0;
    else if (st_nxt != state || act_nxt != active_player) presc <= '0;
    else if (cnt_en) presc <= (presc == PW'(CLK_FREQ - 1)) ? '0 : presc + PW'(1);
  end

  // Free-running digit scan, independent of state and enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt <= '0;
      slot <= 2'd0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      slot <= slot + 2'd1;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Digit select, decode, timeout blanking and decimal point.
  always_comb begin
    anode_active = ~(4'b0001 << slot);
    digit        = adig[slot];
    segments     = (state == S_TMO && !half) ? 7'b1111111 : seg7(digit);
    decimal      = !((slot == 2'd1) && (state == S_PAUSE || (state == S_RUN && half)));
  end
endmodule

// File: tb/tb_chess_timer_display.sv
// Bench for chess_timer_display. A seconds-based reference model runs beside the
// DUT, and every cycle the bench compares all outputs against it.
module tb_chess_timer_display;
  localparam int CF = 10, RD = 2, NP = 3, IM = 1;
  localparam int SET = 0, RUN = 1, PAU = 2, TMO = 3;
  localparam logic [6:0] SEG [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};

  logic       clk = 0, reset = 0, enable = 0;
  logic       btn_c = 0, btn_l = 0, btn_u = 0, btn_d = 0;
  logic [3:0] anode_active;
  logic [6:0] segments;
  logic       decimal;
  logic [1:0] active_player;
  logic       timeout;

  chess_timer_display #(.CLK_FREQ(CF), .REFRESH_DIV(RD), .NUM_PLAYERS(NP), .INIT_MIN(IM)) dut (
    .clk(clk), .reset(reset), .enable(enable), .btn_c(btn_c), .btn_l(btn_l),
    .btn_u(btn_u), .btn_d(btn_d), .anode_active(anode_active), .segments(segments),
    .decimal(decimal), .active_player(active_player), .timeout(timeout));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  // Model: remaining time per player in whole seconds.
  int m_t [NP];
  int m_st, m_act, m_pre, m_rc, m_slot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) m_t[i] = IM * 60;
    m_st = SET; m_act = 0; m_pre = 0; m_rc = 0; m_slot = 0;
  endfunction

  function automatic void model_step(input bit c, input bit l, input bit u, input bit d);
    int  nst, nact, mins;
    bit  tk, last;
    nst  = m_st;
    nact = m_act;
    tk   = (m_st == RUN) && enable && (m_pre == CF - 1);
    case (m_st)
      SET: begin
        for (int i = 0; i < NP; i++) begin
          mins = m_t[i] / 60;
          if (u && !d) mins = (mins >= 99) ? 99 : mins + 1;
          if (d && !u) mins = (mins <= 1) ? 1 : mins - 1;
          m_t[i] = mins * 60;
        end
        if (c) nst = RUN;
      end
      RUN: begin
        last = 0;
        if (tk) begin
          last = (m_t[m_act] <= 1);
          if (m_t[m_act] > 0) m_t[m_act] = m_t[m_act] - 1;
        end
        if (c) nst = PAU;
        else if (tk && last) nst = TMO;
        else if (l) nact = (m_act + 1) % NP;
      end
      PAU: begin
        if (c) nst = RUN;
        else if (u && d) begin
          nst = SET; nact = 0;
          for (int i = 0; i < NP; i++) m_t[i] = IM * 60;
        end
      end
      default: begin
        if (c) begin
          nst = SET; nact = 0;
          for (int i = 0; i < NP; i++) m_t[i] = IM * 60;
        end
      end
    endcase
    if (nst != m_st || nact != m_act) m_pre = 0;
    else if (enable && (m_st == RUN || m_st == TMO)) m_pre = (m_pre + 1) % CF;
    if (m_rc == RD - 1) begin m_rc = 0; m_slot = (m_slot + 1) % 4; end
    else m_rc = m_rc + 1;
    m_st = nst;
    m_act = nact;
  endfunction

  task automatic check_all();
    int t, mm, ss, dg;
    bit half;
    logic [3:0] an;
    logic [6:0] sg;
    logic dp;
    t  = m_t[m_act];
    mm = t / 60;
    ss = t % 60;
    case (m_slot)
      0: dg = ss % 10;
      1: dg = ss / 10;
      2: dg = mm % 10;
      default: dg = mm / 10;
    endcase
    half = (m_pre < CF / 2);
    an   = 4'b1111;
    an[m_slot] = 1'b0;
    sg   = (m_st == TMO && !half) ? 7'b1111111 : SEG[dg];
    dp   = !(m_slot == 1 && (m_st == PAU || (m_st == RUN && half)));
    chk("anode", anode_active, an);
    chk("segments", segments, sg);
    chk("decimal", decimal, dp);
    chk("active_player", active_player, m_act);
    chk("timeout", timeout, (m_st == TMO));
  endtask

  task automatic cyc(input bit c, input bit l, input bit u, input bit d);
    btn_c = c; btn_l = l; btn_u = u; btn_d = d;
    @(posedge clk);
    if (!reset) model_reset();
    else model_step(c, l, u, d);
    #1;
    btn_c = 0; btn_l = 0; btn_u = 0; btn_d = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    // Reset state.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", anode_active, 4'b1110);
    chk("rst_segments", segments, 7'b1000000);
    chk("rst_decimal", decimal, 1'b1);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_player", active_player, 2'd0);
    check_all();
    reset = 1;

    // Idle scan in SET.
    idle(8);

    // Setup: up three, down five (saturates at 1), then start.
    for (int i = 0; i < 3; i++) begin cyc(0, 0, 1, 0); idle(1); end
    for (int i = 0; i < 5; i++) begin cyc(0, 0, 0, 1); idle(1); end
    cyc(0, 0, 1, 1);
    enable = 1;
    cyc(1, 0, 0, 0);
    idle(10);
    chk("p0_after_first_tick", m_t[0], 59);

    // Rotate players at cycle 25 and 10 cycles later.
    idle(14);
    cyc(0, 1, 0, 0);
    chk("rot1_player", active_player, 2'd1);
    idle(9);
    cyc(0, 1, 0, 0);
    chk("rot2_player", active_player, 2'd2);
    idle(13);

    // Pause holds time and lights the dot; btn_l ignored; then resume.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    idle(100);
    cyc(1, 0, 0, 0);
    idle(7);

    // Rotate back to player 0 and run it down to zero.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 1000 && m_st != TMO; i++) cyc(0, 0, 0, 0);
    chk("timeout_reached", timeout, 1'b1);
    cyc(0, 1, 0, 0);
    chk("to_btn_l_ignored", active_player, 2'd0);
    idle(15);
    cyc(1, 0, 0, 0);
    chk("to_exit_player", active_player, 2'd0);
    chk("to_exit_timeout", timeout, 1'b0);
    idle(4);

    // Randomized play.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      bit c, l, u, d;
      enable = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 9) == 0);
      u = ($urandom_range(0, 11) == 0);
      d = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) begin u = 1; d = 1; end
      cyc(c, l, u, d);
    end

    // Clean restart, then asynchronous reset mid-RUN with enable toggling.
    #2 reset = 0;
    #3 reset = 1;
    model_reset();
    idle(2);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 35; i++) begin
      enable = $urandom_range(0, 1);
      cyc(0, 0, 0, 0);
    end
    #2 reset = 0;
    #1;
    model_reset();
    chk("async_rst_anode", anode_active, 4'b1110);
    chk("async_rst_segments", segments, 7'b1000000);
    chk("async_rst_decimal", decimal, 1'b1);
    chk("async_rst_player", active_player, 2'd0);
    check_all();
    #2 reset = 1;

    // enable=0 in RUN freezes time while the scan keeps going.
    enable = 1;
    cyc(1, 0, 0, 0);
    idle(15);
    enable = 0;
    idle(50);
    chk("frozen_p0", m_t[0], 59);
    enable = 1;
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
